fifo_sync_param: RTL and testbench

- Parametrised synchronous FIFO; next generation of the team's single-clock FIFO.
- Adds:
  - generic width and depth, including non-power-of-two depths;
  - programmable almost-full and almost-empty margins;
  - an occupancy count output;
  - a synchronous flush;
  - a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer blocks, e.g. SPI slave to RAM staging.

---
 rtl/fifo_sync_param_if.sv | 34 +++
 rtl/fifo_sync_param.sv | 113 +++++++++++
 tb/tb_fifo_sync_param.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_param_if.sv
// Handshake, data and status bundle between a producer/consumer and fifo_sync_param.
// master drives the requests, slave is the FIFO itself.
interface fifo_sync_param_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                  flush;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CW-1:0]         count;

    modport master (
        output flush, data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  flush, data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with arbitrary depth, programmable almost-full/empty margins,
// occupancy count, synchronous flush and optional first-word-fall-through read.
module fifo_sync_param #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1,
    parameter int FWFT       = 0
) (
    input  logic             clk,
    input  logic             rst,
    fifo_sync_param_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(FIFO_DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LEVEL = CW'(AE_MARGIN);

    if (FIFO_WIDTH < 1) begin : g_bad_width
        $error("FIFO_WIDTH must be at least 1");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("FIFO_DEPTH must be at least 2");
    end
    if (AF_MARGIN < 1 || AF_MARGIN > FIFO_DEPTH - 1) begin : g_bad_af
        $error("AF_MARGIN must lie in 1..FIFO_DEPTH-1");
    end
    if (AE_MARGIN < 1 || AE_MARGIN > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("AE_MARGIN must lie in 1..FIFO_DEPTH-1");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [FIFO_WIDTH-1:0] dout_q;
    logic                  wr_ack_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic full;
    logic empty;
    logic rd_ok;
    logic wr_ok;

    // Pointers wrap explicitly so depth need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign rd_ok = bus.rd_en && !empty;
    assign wr_ok = bus.wr_en && (!full || rd_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            wr_ack_q    <= wr_ok;
            overflow_q  <= bus.wr_en && !wr_ok;
            underflow_q <= bus.rd_en && !rd_ok;
            if (FWFT == 0 && rd_ok) begin
                dout_q <= mem[rd_ptr];
            end
        end
    end

    // Storage is not reset; a write coinciding with flush is dropped.
    always_ff @(posedge clk) begin
        if (wr_ok && !bus.flush && !rst) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    assign bus.data_out    = (FWFT != 0) ? (empty ? '0 : mem[rd_ptr]) : dout_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostfull  = (count_q >= AF_LEVEL) && !full;
    assign bus.almostempty = (count_q <= AE_LEVEL) && !empty;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives three FIFO configurations with one shared stimulus stream and checks each
// against a queue-based reference model, plus a directed table for the depth-8 FIFO.
module tb_fifo_sync_param;
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_sync_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) b8 ();
    fifo_sync_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) b5 ();
    fifo_sync_param_if #(.FIFO_WIDTH(16), .FIFO_DEPTH(6)) bf ();

    fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_MARGIN(1), .AE_MARGIN(1), .FWFT(0))
        u8 (.clk(clk), .rst(rst), .bus(b8));
    fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AF_MARGIN(2), .AE_MARGIN(2), .FWFT(0))
        u5 (.clk(clk), .rst(rst), .bus(b5));
    fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_MARGIN(2), .AE_MARGIN(1), .FWFT(1))
        uf (.clk(clk), .rst(rst), .bus(bf));

    int depth [3] = '{8, 5, 6};
    int af_m  [3] = '{1, 2, 2};
    int ae_m  [3] = '{1, 2, 1};
    bit fw    [3] = '{1'b0, 1'b0, 1'b1};

    logic [15:0] mq0 [$];
    logic [15:0] mq1 [$];
    logic [15:0] mq2 [$];
    logic [15:0] dout_m [3];
    bit          ack_m  [3];
    bit          ovf_m  [3];
    bit          udf_m  [3];

    int ncmp  = 0;
    int nfail = 0;

    typedef struct {
        bit          fl;
        bit          we;
        bit          re;
        logic [15:0] din;
        int          cnt;
        bit          ack;
        bit          ovf;
        bit          udf;
        logic [15:0] dout;
    } vec_t;

    vec_t vecs [$];

    task automatic check_eq(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit fl, input bit we, input bit re, input logic [15:0] d);
        b8.flush = fl; b8.wr_en = we; b8.rd_en = re; b8.data_in = d;
        b5.flush = fl; b5.wr_en = we; b5.rd_en = re; b5.data_in = d;
        bf.flush = fl; bf.wr_en = we; bf.rd_en = re; bf.data_in = d;
    endtask

    task automatic model_reset();
        mq0.delete(); mq1.delete(); mq2.delete();
        for (int i = 0; i < 3; i++) begin
            dout_m[i] = '0; ack_m[i] = 0; ovf_m[i] = 0; udf_m[i] = 0;
        end
    endtask

    task automatic model_step(input int id, input bit fl, input bit we, input bit re,
                              input logic [15:0] d);
        logic [15:0] lq [$];
        logic [15:0] w;
        bit rd_ok;
        bit wr_ok;
        case (id)
            0:       lq = mq0;
            1:       lq = mq1;
            default: lq = mq2;
        endcase
        if (fl) begin
            lq.delete();
            ack_m[id] = 0; ovf_m[id] = 0; udf_m[id] = 0; dout_m[id] = '0;
        end else begin
            rd_ok = re && (lq.size() > 0);
            wr_ok = we && ((lq.size() < depth[id]) || rd_ok);
            ack_m[id] = wr_ok;
            ovf_m[id] = we && !wr_ok;
            udf_m[id] = re && !rd_ok;
            if (rd_ok) begin
                w = lq.pop_front();
                if (!fw[id]) dout_m[id] = w;
            end
            if (wr_ok) lq.push_back(d);
        end
        case (id)
            0:       mq0 = lq;
            1:       mq1 = lq;
            default: mq2 = lq;
        endcase
    endtask

    task automatic check_all(input int id);
        int          sz;
        int          cnt;
        logic [15:0] head;
        logic [15:0] dout;
        logic [15:0] exp_dout;
        bit ack, ovf, udf, fu, em, afl, ael;
        string p;
        case (id)
            0: begin
                sz = mq0.size(); head = (sz > 0) ? mq0[0] : 16'h0;
                cnt = int'(b8.count); dout = b8.data_out; ack = b8.wr_ack; ovf = b8.overflow;
                udf = b8.underflow; fu = b8.full; em = b8.empty; afl = b8.almostfull; ael = b8.almostempty;
            end
            1: begin
                sz = mq1.size(); head = (sz > 0) ? mq1[0] : 16'h0;
                cnt = int'(b5.count); dout = b5.data_out; ack = b5.wr_ack; ovf = b5.overflow;
                udf = b5.underflow; fu = b5.full; em = b5.empty; afl = b5.almostfull; ael = b5.almostempty;
            end
            default: begin
                sz = mq2.size(); head = (sz > 0) ? mq2[0] : 16'h0;
                cnt = int'(bf.count); dout = bf.data_out; ack = bf.wr_ack; ovf = bf.overflow;
                udf = bf.underflow; fu = bf.full; em = bf.empty; afl = bf.almostfull; ael = bf.almostempty;
            end
        endcase
        exp_dout = fw[id] ? head : dout_m[id];
        p = $sformatf("d%0d", depth[id]);
        check_eq({p, ".count"}, cnt, sz);
        check_eq({p, ".data_out"}, int'(dout), int'(exp_dout));
        check_eq({p, ".wr_ack"}, int'(ack), int'(ack_m[id]));
        check_eq({p, ".overflow"}, int'(ovf), int'(ovf_m[id]));
        check_eq({p, ".underflow"}, int'(udf), int'(udf_m[id]));
        check_eq({p, ".full"}, int'(fu), int'(sz == depth[id]));
        check_eq({p, ".empty"}, int'(em), int'(sz == 0));
        check_eq({p, ".almostfull"}, int'(afl), int'(sz >= depth[id] - af_m[id] && sz != depth[id]));
        check_eq({p, ".almostempty"}, int'(ael), int'(sz <= ae_m[id] && sz != 0));
    endtask

    task automatic cycle(input bit fl, input bit we, input bit re, input logic [15:0] d);
        drive(fl, we, re, d);
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, fl, we, re, d);
        #1;
        for (int i = 0; i < 3; i++) check_all(i);
    endtask

    function automatic void add(input bit fl, input bit we, input bit re, input logic [15:0] din,
                                input int cnt, input bit ack, input bit ovf, input bit udf,
                                input logic [15:0] dout);
        vec_t v;
        v.fl = fl; v.we = we; v.re = re; v.din = din; v.cnt = cnt;
        v.ack = ack; v.ovf = ovf; v.udf = udf; v.dout = dout;
        vecs.push_back(v);
    endfunction

    initial begin
        // Expected behaviour of the depth-8 standard-mode FIFO, written from the test plan.
        for (int k = 0; k < 8; k++) add(0, 1, 0, 16'(k + 1), k + 1, 1, 0, 0, 16'h0000);
        add(0, 1, 0, 16'h0009, 8, 0, 1, 0, 16'h0000);
        for (int k = 0; k < 8; k++) add(0, 0, 1, 16'h0000, 7 - k, 0, 0, 0, 16'(k + 1));
        add(0, 0, 1, 16'h0000, 0, 0, 0, 1, 16'h0008);
        add(0, 1, 1, 16'h0055, 1, 1, 0, 1, 16'h0008);
        for (int k = 0; k < 7; k++) add(0, 1, 0, 16'(16'h0060 + k), 2 + k, 1, 0, 0, 16'h0008);
        add(0, 1, 1, 16'h0077, 8, 1, 0, 0, 16'h0055);
        add(1, 1, 1, 16'h0099, 0, 0, 0, 0, 16'h0000);

        rst = 1'b1;
        drive(0, 0, 0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) check_all(i);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].fl, vecs[i].we, vecs[i].re, vecs[i].din);
            check_eq($sformatf("vec%0d.count", i), int'(b8.count), vecs[i].cnt);
            check_eq($sformatf("vec%0d.wr_ack", i), int'(b8.wr_ack), int'(vecs[i].ack));
            check_eq($sformatf("vec%0d.overflow", i), int'(b8.overflow), int'(vecs[i].ovf));
            check_eq($sformatf("vec%0d.underflow", i), int'(b8.underflow), int'(vecs[i].udf));
            check_eq($sformatf("vec%0d.data_out", i), int'(b8.data_out), int'(vecs[i].dout));
        end

        // FWFT: a word written into an empty FIFO is visible without a read.
        cycle(0, 1, 0, 16'hABCD);
        check_eq("fwft.first_word", int'(bf.data_out), 16'hABCD);
        cycle(0, 1, 0, 16'h1111);
        cycle(0, 1, 0, 16'h2222);
        check_eq("fwft.head_held", int'(bf.data_out), 16'hABCD);
        check_eq("flush.pre_count", int'(b8.count), 3);
        cycle(1, 1, 0, 16'h3333);
        check_eq("flush.count", int'(b8.count), 0);
        check_eq("flush.empty", int'(b8.empty), 1);
        check_eq("flush.wr_ack", int'(b8.wr_ack), 0);
        check_eq("flush.data_out", int'(b8.data_out), 0);
        check_eq("flush.fwft_data_out", int'(bf.data_out), 0);

        // Interleaved traffic that walks the depth-5 pointers across the wrap point.
        for (int k = 0; k < 12; k++) cycle(0, k < 10, k >= 3, 16'(16'h0500 + k));
        for (int k = 0; k < 6; k++) cycle(0, 0, 1, 16'h0);

        for (int n = 0; n < 1500; n++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 45, 16'($urandom));
        end

        // Asynchronous reset between edges clears everything immediately.
        drive(0, 1, 1, 16'h7E7E);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) check_all(i);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 200; n++) begin
            cycle(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
